card_deal_arbiter: RTL

//  Shares the single card LUT (pip -> number) between the player-hand and dealer-hand controllers.

---
 rtl/card_deal_arbiter_pkg.sv | 15 +
 rtl/card_deal_arbiter_if.sv | 29 ++
 rtl/card_deal_arbiter_deck_tracker.sv | 38 +++
 rtl/card_deal_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/card_deal_arbiter_pkg.sv
// Shared types and constants for the card deal arbiter and its deck tracker.
package tenthirty_pkg;

   localparam int CARD_W    = 4;
   localparam int RANK_MAX  = 13;
   localparam int DECK_SIZE = 52;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CHECK} state_t;
   typedef enum logic {DST_PLAYER, DST_DEALER} dst_t;

   function automatic logic is_rank(input logic [CARD_W-1:0] v);
      return (v != '0) && (v <= CARD_W'(RANK_MAX));
   endfunction

endpackage

// File: rtl/card_deal_arbiter_if.sv
// Hand-controller / LUT side signals of the card deal arbiter.
interface card_deal_arbiter_if;
   import tenthirty_pkg::*;

   logic              req_p;
   logic              req_d;
   logic              new_round;
   logic              lut_pip;
   logic [CARD_W-1:0] lut_number;
   logic              gnt_p;
   logic              gnt_d;
   logic              card_vld;
   logic [CARD_W-1:0] card_val;
   dst_t              card_dst;
   logic              busy;
   logic              deck_empty;
   logic              deal_err;

   modport master (
      output req_p, req_d, new_round, lut_number,
      input  lut_pip, gnt_p, gnt_d, card_vld, card_val, card_dst, busy, deck_empty, deal_err
   );

   modport slave (
      input  req_p, req_d, new_round, lut_number,
      output lut_pip, gnt_p, gnt_d, card_vld, card_val, card_dst, busy, deck_empty, deal_err
   );

endinterface

// File: rtl/card_deal_arbiter_deck_tracker.sv
// Per-rank copy counters and dealt-card counter for one deck.
module deck_tracker
   import tenthirty_pkg::*;
#(
   parameter int COPIES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   input  logic [CARD_W-1:0] rank,
   output logic              full_rank,
   output logic              empty
);

   logic [2:0] cnt [1:RANK_MAX];
   logic [5:0] dealt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 1; i <= RANK_MAX; i++) cnt[i] <= '0;
         dealt <= '0;
      end else if (inc) begin
         for (int i = 1; i <= RANK_MAX; i++)
            if (rank == CARD_W'(i) && cnt[i] != 3'(COPIES)) cnt[i] <= cnt[i] + 3'd1;
         if (dealt != 6'(DECK_SIZE)) dealt <= dealt + 6'd1;
      end
   end

   always_comb begin
      full_rank = 1'b0;
      for (int i = 1; i <= RANK_MAX; i++)
         if (rank == CARD_W'(i) && cnt[i] == 3'(COPIES)) full_rank = 1'b1;
   end

   assign empty = (dealt == 6'(DECK_SIZE));

endmodule

// File: rtl/card_deal_arbiter.sv
// Round-robin draw arbiter in front of the shared card LUT; redraws illegal cards.
// DECK_TRACK_EN builds the per-rank copy screen and deck_empty; otherwise only 0/14/15 are rejected.
//
//   state | meaning
//   IDLE  | no draw in flight; arbitrate requests, apply pending refill
//   ISSUE | lut_pip strobe (grant on the first issue of a draw)
//   WAIT  | remaining LUT latency cycles
//   CHECK | screen lut_number: accept, redraw, or give up
module card_deal_arbiter
   import tenthirty_pkg::*;
#(
   parameter int LUT_LAT    = 1,
   parameter int MAX_REDRAW = 15
`ifdef DECK_TRACK_EN
   , parameter int COPIES   = 4
`endif
) (
   input  logic               clk,
   input  logic               rst,
   card_deal_arbiter_if.slave bus
);

   state_t            state, state_nx;
   dst_t              win, last_gnt, pick;
   logic [4:0]        retry;
   logic [2:0]        wait_cnt;
   logic              nr_pend, deal_err_q, deck_empty_w, accept;
   logic              refill, any_req, first_issue, give_up;
   logic              card_vld_q, card_dst_q;
   logic [CARD_W-1:0] card_val_q;

   assign refill      = (state == IDLE) && (bus.new_round || nr_pend);
   assign any_req     = bus.req_p || bus.req_d;
   assign first_issue = (state == ISSUE) && (retry == '0);
   assign give_up     = (retry == 5'(MAX_REDRAW - 1));

   always_comb begin
      if (bus.req_p && bus.req_d) pick = (last_gnt == DST_PLAYER) ? DST_DEALER : DST_PLAYER;
      else if (bus.req_d)         pick = DST_DEALER;
      else                        pick = DST_PLAYER;
   end

`ifdef DECK_TRACK_EN
   logic full_rank_w, inc_w;
   assign inc_w = (state == CHECK) && accept;

   deck_tracker #(.COPIES(COPIES)) u_deck (
      .clk       (clk),
      .rst       (rst),
      .clr       (refill),
      .inc       (inc_w),
      .rank      (bus.lut_number),
      .full_rank (full_rank_w),
      .empty     (deck_empty_w)
   );
   assign accept = is_rank(bus.lut_number) && !full_rank_w;
`else
   assign deck_empty_w = 1'b0;
   assign accept       = is_rank(bus.lut_number);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!refill && any_req && !deck_empty_w && !deal_err_q) state_nx = ISSUE;
         ISSUE:   state_nx = (LUT_LAT == 1) ? CHECK : WAIT;
         WAIT:    if (wait_cnt == '0) state_nx = CHECK;
         CHECK:   state_nx = (accept || give_up) ? IDLE : ISSUE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.lut_pip    = (state == ISSUE);
      bus.gnt_p      = first_issue && (win == DST_PLAYER);
      bus.gnt_d      = first_issue && (win == DST_DEALER);
      bus.busy       = (state != IDLE);
      bus.deck_empty = deck_empty_w;
      bus.deal_err   = deal_err_q;
      bus.card_vld   = card_vld_q;
      bus.card_val   = card_val_q;
      bus.card_dst   = dst_t'(card_dst_q);
   end

   // A refill requested mid-draw is held until the in-flight card has been counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         win        <= DST_PLAYER;
         last_gnt   <= DST_DEALER;
         retry      <= '0;
         wait_cnt   <= '0;
         nr_pend    <= 1'b0;
         deal_err_q <= 1'b0;
         card_vld_q <= 1'b0;
         card_val_q <= '0;
         card_dst_q <= 1'b0;
      end else begin
         card_vld_q <= 1'b0;
         if (state != IDLE && bus.new_round) nr_pend <= 1'b1;
         if (refill) begin
            nr_pend    <= 1'b0;
            deal_err_q <= 1'b0;
         end
         case (state)
            IDLE: if (state_nx == ISSUE) begin
               win   <= pick;
               retry <= '0;
            end
            ISSUE: begin
               if (retry == '0) last_gnt <= win;
               wait_cnt <= 3'(LUT_LAT - 2);
            end
            WAIT: wait_cnt <= wait_cnt - 3'd1;
            CHECK: begin
               if (accept) begin
                  card_vld_q <= 1'b1;
                  card_val_q <= bus.lut_number;
                  card_dst_q <= win;
               end else if (give_up) begin
                  deal_err_q <= 1'b1;
               end else begin
                  retry <= retry + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
